// File: rtl/simon_enc_ctrl.sv
// -----------------------------------------------------------------------------
// simon_enc_ctrl
//
// Sequencing controller for a Simon 32/64 encryption engine. It asks the key
// schedule to expand the key and waits for that to finish. It then accepts one
// 32-bit plaintext at a time and runs the Feistel rounds itself, pulling one
// round key per cycle by index. It presents the ciphertext on a valid/ready
// port. Rekey requests that arrive mid-block are held pending and serviced
// before the next plaintext is accepted.
//
// Ports
//   clk       in   1   single clock, rising edge
//   rst       in   1   synchronous reset, active-low
//   ks_start  out  1   one-cycle request to (re)expand the key
//   ks_done   in   1   key schedule has all round keys valid (level)
//   rk_idx    out  5   round-key index (0 outside the round loop)
//   rk        in  16   round key for rk_idx, valid in the same cycle
//   pt_valid  in   1   plaintext offered
//   pt_ready  out  1   plaintext can be accepted
//   pt        in  32   plaintext {x, y}
//   ct_valid  out  1   ciphertext available
//   ct_ready  in   1   downstream accepts ciphertext
//   ct        out 32   ciphertext {x, y}
//   rekey     in   1   key changed upstream, re-expansion requested
//   busy      out  1   high in every state except READY
// -----------------------------------------------------------------------------
module simon_enc_ctrl #(
    parameter int ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ks_start,
    input  logic        ks_done,
    output logic [4:0]  rk_idx,
    input  logic [15:0] rk,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [31:0] pt,
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic [31:0] ct,
    input  logic        rekey,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_KS_REQ,
        S_KS_WAIT,
        S_READY,
        S_ROUND,
        S_OUT
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [4:0]  r_q, r_d;
    logic        rekey_pend_q, rekey_pend_d;
    logic        ks_start_q, ks_start_d;
    logic        ct_valid_q, ct_valid_d;
    logic [31:0] ct_q, ct_d;
    logic [4:0]  rk_idx_q, rk_idx_d;
    logic        busy_q, busy_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] x_next;

    // Simon round function: (rotl1 & rotl8) ^ rotl2, all 16-bit.
    function automatic logic [15:0] simon_f(input logic [15:0] v);
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r8;
        r1 = {v[14:0], v[15]};
        r2 = {v[13:0], v[15:14]};
        r8 = {v[7:0], v[15:8]};
        return (r1 & r8) ^ r2;
    endfunction

    assign x_next = y_q ^ simon_f(x_q) ^ rk;

    // pt_ready depends on the live rekey input so that a rekey arriving in the
    // same cycle as a plaintext always wins the tie.
    assign pt_ready = (state_q == S_READY) && !rekey && !rekey_pend_q;
    assign ks_start = ks_start_q;
    assign rk_idx   = rk_idx_q;
    assign ct_valid = ct_valid_q;
    assign ct       = ct_q;
    assign busy     = busy_q;

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        rekey_pend_d = rekey_pend_q;
        ks_start_d   = 1'b0;
        ct_valid_d   = ct_valid_q;
        ct_d         = ct_q;
        rk_idx_d     = 5'd0;
        x_d          = x_q;
        y_d          = y_q;

        unique case (state_q)
            S_KS_REQ: begin
                // Reset lands here with ks_start low; the request is raised on
                // the first active cycle. Entry from READY arrives with it
                // already high, so the pulse is always exactly one cycle.
                if (ks_start_q) begin
                    state_d = S_KS_WAIT;
                end else begin
                    ks_start_d = 1'b1;
                end
            end
            S_KS_WAIT: begin
                if (ks_done) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (rekey || rekey_pend_q) begin
                    state_d      = S_KS_REQ;
                    rekey_pend_d = 1'b0;
                    ks_start_d   = 1'b1;
                end else if (pt_valid) begin
                    x_d     = pt[31:16];
                    y_d     = pt[15:0];
                    r_d     = 5'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                x_d = x_next;
                y_d = x_q;
                r_d = r_q + 5'd1;
                if (rekey) begin
                    rekey_pend_d = 1'b1;
                end
                if (r_q == LAST_ROUND) begin
                    ct_d       = {x_next, x_q};
                    ct_valid_d = 1'b1;
                    state_d    = S_OUT;
                end else begin
                    rk_idx_d = r_q + 5'd1;
                end
            end
            S_OUT: begin
                if (rekey) begin
                    rekey_pend_d = 1'b1;
                end
                if (ct_ready) begin
                    ct_valid_d = 1'b0;
                    state_d    = S_READY;
                end
            end
            default: begin
                state_d = S_KS_REQ;
            end
        endcase

        busy_d = (state_d != S_READY);
    end

    // ---- control registers (reset) ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_KS_REQ;
            r_q          <= 5'd0;
            rekey_pend_q <= 1'b0;
            ks_start_q   <= 1'b0;
            ct_valid_q   <= 1'b0;
            ct_q         <= 32'd0;
            rk_idx_q     <= 5'd0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            rekey_pend_q <= rekey_pend_d;
            ks_start_q   <= ks_start_d;
            ct_valid_q   <= ct_valid_d;
            ct_q         <= ct_d;
            rk_idx_q     <= rk_idx_d;
            busy_q       <= busy_d;
        end
    end

    // ---- Feistel datapath (no reset, always reloaded on acceptance) ----
    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

endmodule

// File: tb/tb_simon_enc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simon_enc_ctrl
//
// Bench for simon_enc_ctrl. Models the key schedule (round keys computed from a
// 64-bit key, ks_done driven with a programmable delay) and checks ciphertexts
// against a Simon 32/64 reference written from the cipher definition.
// -----------------------------------------------------------------------------
module tb_simon_enc_ctrl;

    localparam int ROUNDS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        ks_start;
    logic        ks_done = 1'b0;
    logic [4:0]  rk_idx;
    logic [15:0] rk;
    logic        pt_valid;
    logic        pt_ready;
    logic [31:0] pt;
    logic        ct_valid;
    logic        ct_ready;
    logic [31:0] ct;
    logic        rekey;
    logic        busy;

    int total = 0;
    int bad   = 0;

    simon_enc_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .ks_start (ks_start),
        .ks_done  (ks_done),
        .rk_idx   (rk_idx),
        .rk       (rk),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt       (pt),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct       (ct),
        .rekey    (rekey),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference cipher ----------------
    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
        return rotl(v, 16 - n);
    endfunction

    function automatic logic [15:0] round_key(input logic [63:0] key, input int idx);
        logic [15:0] k [0:31];
        logic [61:0] z;
        logic [15:0] t;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            t = rotr(k[i-1], 3) ^ k[i-3];
            t = t ^ rotr(t, 1);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61 - (i - 4)]} ^ 16'h0003;
        end
        return k[idx];
    endfunction

    function automatic logic [31:0] encrypt(input logic [63:0] key, input logic [31:0] p);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ round_key(key, i);
            y = t;
        end
        return {x, y};
    endfunction

    // ---------------- key schedule model ----------------
    logic [63:0] cur_key;
    logic [15:0] rks [0:31];
    int          ks_delay = 1;
    int          ks_dn    = 0;

    assign rk = rks[rk_idx];

    task automatic load_key(input logic [63:0] key);
        cur_key = key;
        for (int i = 0; i < 32; i++) rks[i] = round_key(key, i);
    endtask

    always @(posedge clk) begin
        if (ks_start === 1'b1) begin
            ks_done <= 1'b0;
            ks_dn   <= ks_delay;
        end else if (ks_dn > 0) begin
            ks_dn <= ks_dn - 1;
            if (ks_dn == 1) ks_done <= 1'b1;
        end
    end

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          ks_cnt = 0;
    int          last_ks_cyc = -1;
    logic [31:0] acc_q[$];
    int          acc_t[$];
    logic [31:0] out_q[$];
    int          out_t[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ks_start === 1'b1) begin
            ks_cnt      <= ks_cnt + 1;
            last_ks_cyc <= cyc;
        end
        if (pt_valid === 1'b1 && pt_ready === 1'b1) begin
            acc_q.push_back(pt);
            acc_t.push_back(cyc);
        end
        if (ct_valid === 1'b1 && ct_ready === 1'b1) begin
            out_q.push_back(ct);
            out_t.push_back(cyc);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_ct(output int lat);
        lat = 0;
        while (ct_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    // Offers p while in READY; returns once ct_valid is seen.
    task automatic run_block(input logic [31:0] p, output logic [31:0] c, output int lat);
        pt       = p;
        pt_valid = 1'b1;
        step();
        pt_valid = 1'b0;
        wait_ct(lat);
        c = ct;
    endtask

    typedef struct {
        logic [63:0] key;
        logic [31:0] pt;
        logic [31:0] exp_ct;
    } vec_t;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;
    localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [0:5];
        logic [63:0] k2;
        logic [63:0] k4;
        logic [31:0] c;
        logic [31:0] p;
        logic [31:0] sp [0:3];
        int          lat;
        int          k0;
        int          a0;
        int          o0;
        int          n;
        int          idx;
        int          errs;
        bit          ok;

        rst      = 1'b0;
        pt_valid = 1'b0;
        pt       = '0;
        ct_ready = 1'b0;
        rekey    = 1'b0;
        ks_delay = 12;
        load_key(KAT_KEY);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ks_start", ks_start, 0);
        check("rst_busy", busy, 1);
        check("rst_pt_ready", pt_ready, 0);
        check("rst_ct_valid", ct_valid, 0);
        check("rst_ct", ct, 0);
        check("rst_rk_idx", rk_idx, 0);

        // Expansion with ks_done held low well past 10 cycles
        k0   = ks_cnt;
        rst  = 1'b1;
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy !== 1'b1 || pt_ready !== 1'b0) errs++;
        end
        check("slow_ks_not_ready", errs, 0);
        wait_ready(ok);
        check("ks_ready_reached", ok, 1);
        check("ks_single_start", ks_cnt - k0, 1);
        ks_delay = 1;

        // Known answer with output backpressure
        run_block(KAT_PT, c, lat);
        check("kat_latency", lat, 32);
        check("kat_ct", c, KAT_CT);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ct !== KAT_CT || ct_valid !== 1'b1 || pt_ready !== 1'b0) errs++;
        end
        check("bp_hold", errs, 0);
        step();
        ct_ready = 1'b1;
        step();
        ct_ready = 1'b0;
        check("bp_ct_valid_drop", ct_valid, 0);
        @(negedge clk);
        check("bp_pt_ready_rise", pt_ready, 1);

        // rekey together with ct_ready in OUT
        step();
        p = $urandom;
        run_block(p, c, lat);
        check("out_rekey_ct", c, encrypt(cur_key, p));
        a0       = acc_q.size();
        rekey    = 1'b1;
        ct_ready = 1'b1;
        step();
        rekey    = 1'b0;
        ct_ready = 1'b0;
        pt_valid = 1'b1;
        check("out_rekey_ct_drop", ct_valid, 0);
        @(negedge clk);
        check("out_rekey_pt_ready", pt_ready, 0);
        step();
        check("out_rekey_ks_start", ks_start, 1);
        wait_ready(ok);
        pt_valid = 1'b0;
        check("out_rekey_ready", ok, 1);
        check("out_rekey_no_accept", acc_q.size() - a0, 0);

        // Table-driven vectors; a key change goes through a rekey/pt_valid tie
        k2 = {$urandom, $urandom};
        k4 = {$urandom, $urandom};
        vecs[0] = '{KAT_KEY, KAT_PT, KAT_CT};
        vecs[1] = '{KAT_KEY, 32'h0, 32'h0};
        vecs[2] = '{k2, 32'h0, 32'h0};
        vecs[3] = '{k2, 32'h0, 32'h0};
        vecs[4] = '{k4, 32'h0, 32'h0};
        vecs[5] = '{KAT_KEY, KAT_PT, KAT_CT};
        for (int i = 1; i < 5; i++) begin
            vecs[i].pt     = $urandom;
            vecs[i].exp_ct = encrypt(vecs[i].key, vecs[i].pt);
        end
        ct_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].key != cur_key) begin
                load_key(vecs[i].key);
                a0       = acc_q.size();
                rekey    = 1'b1;
                pt_valid = 1'b1;
                pt       = vecs[i].pt;
                @(negedge clk);
                check("tie_pt_ready", pt_ready, 0);
                step();
                rekey    = 1'b0;
                pt_valid = 1'b0;
                check("tie_no_accept", acc_q.size() - a0, 0);
                check("tie_ks_start", ks_start, 1);
                wait_ready(ok);
                check("tie_ready", ok, 1);
            end
            run_block(vecs[i].pt, c, lat);
            check($sformatf("vec%0d_ct", i), c, vecs[i].exp_ct);
            check($sformatf("vec%0d_lat", i), lat, 32);
            step();
            check($sformatf("vec%0d_done", i), ct_valid, 0);
        end

        // rekey pulsed at round 10
        a0       = acc_q.size();
        k0       = ks_cnt;
        p        = $urandom;
        pt       = p;
        pt_valid = 1'b1;
        step();
        pt_valid = 1'b0;
        repeat (10) step();
        rekey = 1'b1;
        step();
        rekey = 1'b0;
        wait_ct(lat);
        check("r10_ct", ct, encrypt(cur_key, p));
        p        = $urandom;
        pt       = p;
        pt_valid = 1'b1;
        n        = 0;
        while (acc_q.size() < a0 + 2 && n < 60) begin
            step();
            n++;
        end
        pt_valid = 1'b0;
        check("r10_accepted", acc_q.size(), a0 + 2);
        check("r10_single_ks", ks_cnt - k0, 1);
        if (acc_q.size() >= a0 + 2) check("r10_ks_before_accept", acc_t[a0+1] > last_ks_cyc, 1);
        wait_ct(lat);
        check("r10_next_ct", ct, encrypt(cur_key, p));
        step();

        // Reset at round 15
        p        = $urandom;
        pt       = p;
        pt_valid = 1'b1;
        step();
        pt_valid = 1'b0;
        repeat (15) step();
        rst = 1'b0;
        step();
        check("mrst_ct_valid", ct_valid, 0);
        check("mrst_busy", busy, 1);
        check("mrst_rk_idx", rk_idx, 0);
        k0  = ks_cnt;
        rst = 1'b1;
        wait_ready(ok);
        check("mrst_ready", ok, 1);
        check("mrst_ks_start", ks_cnt - k0, 1);
        p = $urandom;
        run_block(p, c, lat);
        check("mrst_next_ct", c, encrypt(cur_key, p));
        step();

        // Back-to-back streaming
        for (int i = 0; i < 4; i++) sp[i] = $urandom;
        a0       = acc_q.size();
        o0       = out_q.size();
        idx      = 0;
        n        = 0;
        pt       = sp[0];
        pt_valid = 1'b1;
        while (out_q.size() < o0 + 4 && n < 400) begin
            step();
            n++;
            if (acc_q.size() - a0 > idx) begin
                idx++;
                if (idx < 4) pt = sp[idx];
                else pt_valid = 1'b0;
            end
        end
        pt_valid = 1'b0;
        check("stream_count", out_q.size() - o0, 4);
        if (out_q.size() >= o0 + 4 && acc_q.size() >= a0 + 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("stream%0d_ct", i), out_q[o0+i], encrypt(cur_key, sp[i]));
            for (int i = 0; i < 3; i++)
                check($sformatf("stream%0d_spacing", i), acc_t[a0+i+1] - acc_t[a0+i], 34);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
